fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Presents the current PC to instruction memory over a valid/ready request channel and tells the PC register when to advance (PCWrite).
- Matches in-order memory responses with their PCs and buffers up to DEPTH instructions toward decode.
- Discards all queued and in-flight fetches when the control path redirects the PC (branch, jump, jr, exception).

---
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 77 +++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: PC, instruction-memory and decode handshake signals of the fetch stage.
interface fetch_queue_if;
   logic [31:0] PC;
   logic        redirect;
   logic        PCWrite;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   modport master (
      input  PC, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
      output PCWrite, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4
   );
   modport slave (
      output PC, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
      input  PCWrite, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: issues PC fetches, pairs in-order responses with their PCs, buffers them for decode.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.master f
);
   localparam int CW = AW + 1;
   localparam int SW = AW + 2;
   logic [CW-1:0] count_q, count_d, drop_q, drop_d, pend_q, pend_d;
   logic [AW-1:0] wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;
   logic [31:0]   pc_q [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic fire, fill, drop_hit, pop;
   always_comb begin
      f.imem_req_valid = reset && !f.redirect && ((SW'(count_q) + SW'(drop_q)) < SW'(DEPTH));
      f.imem_req_addr  = f.PC;
      fire             = f.imem_req_valid && f.imem_req_ready;
      f.PCWrite        = fire || f.redirect;
      drop_hit         = f.imem_resp_valid && (drop_q != '0);
      fill             = f.imem_resp_valid && (drop_q == '0) && (pend_q != '0);
      f.if_valid       = !f.redirect && (count_q != '0) && filled_q[rd_q];
      pop              = f.if_valid && f.id_ready;
      f.if_instr       = instr_q[rd_q];
      f.if_pc          = pc_q[rd_q];
      f.if_pc_plus4    = {pc_q[rd_q][31], pc_q[rd_q][30:0] + 31'd4};
      // pending fetches become drops on redirect; one landing this very cycle is dropped already
      drop_d  = drop_q - CW'(drop_hit) + (f.redirect ? pend_q - CW'(fill) : '0);
      count_d = f.redirect ? '0 : count_q + CW'(fire) - CW'(pop);
      pend_d  = f.redirect ? '0 : pend_q + CW'(fire) - CW'(fill);
      wr_d    = f.redirect ? '0 : wr_q + AW'(fire);
      fill_d  = f.redirect ? '0 : fill_q + AW'(fill);
      rd_d    = f.redirect ? '0 : rd_q + AW'(pop);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q  <= '0;
         drop_q   <= '0;
         pend_q   <= '0;
         wr_q     <= '0;
         fill_q   <= '0;
         rd_q     <= '0;
         filled_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         drop_q  <= drop_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         fill_q  <= fill_d;
         rd_q    <= rd_d;
         if (f.redirect) begin
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               pc_q[i]    <= '0;
               instr_q[i] <= '0;
            end
         end else begin
            if (pop) filled_q[rd_q] <= 1'b0;
            if (fill) begin
               instr_q[fill_q]  <= f.imem_resp_data;
               filled_q[fill_q] <= 1'b1;
            end
            if (fire) begin
               pc_q[wr_q]     <= f.PC;
               filled_q[wr_q] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: PC register and variable-latency memory models around fetch_queue, with a
// scoreboard of fetched {pc, instr} pairs checked in order at decode.
module tb_fetch_queue;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   fetch_queue_if fq();
   fetch_queue #(.DEPTH(2), .AW(1)) dut (.clk(clk), .reset(reset), .f(fq));
   typedef struct {logic [31:0] addr; int due;} mreq_t;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
   typedef struct {logic [31:0] pc; logic [31:0] plus4;} vec_t;
   mreq_t mq[$];
   exp_t  sb[$];
   mreq_t m_tmp;
   exp_t  e_tmp;
   exp_t  e_chk;
   vec_t  tbl[5];
   int checks = 0, errors = 0;
   int lat = 1, cyc = 0, fires = 0, pops = 0, f0 = 0, p0 = 0;
   bit ok;
   logic [31:0] pc_r, tgt;
   logic fire;
   assign fire = fq.imem_req_valid && fq.imem_req_ready;
   assign fq.PC = pc_r;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic redir(input logic [31:0] t);
      tgt = t;
      fq.redirect = 1'b1;
      @(posedge clk);
      #1 fq.redirect = 1'b0;
   endtask
   task automatic wait_valid(input string name, output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (fq.if_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: if_valid never rose within 40 cycles", name);
      end
   endtask
   task automatic settle();
      fq.imem_req_ready = 1'b0;
      fq.id_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask
   // PC register: advances on accepted fetch, loads target on redirect
   always @(posedge clk or negedge reset)
      if (!reset) pc_r <= '0;
      else if (fq.PCWrite) pc_r <= fq.redirect ? tgt : pc_r + 32'd4;
   // In-order memory, response lat cycles after acceptance
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         fq.imem_resp_valid <= 1'b0;
         fq.imem_resp_data  <= '0;
      end else begin
         cyc++;
         if (fq.imem_resp_valid) void'(mq.pop_front());
         if (fire) begin
            m_tmp.addr = fq.imem_req_addr;
            m_tmp.due  = cyc + lat - 1;
            mq.push_back(m_tmp);
            fires++;
         end
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            fq.imem_resp_valid <= 1'b1;
            fq.imem_resp_data  <= mem_word(mq[0].addr);
         end else begin
            fq.imem_resp_valid <= 1'b0;
            fq.imem_resp_data  <= 32'hDEAD_BEEF;
         end
      end
   end
   always @(posedge clk or negedge reset) begin
      if (!reset) sb.delete();
      else if (fq.redirect) sb.delete();
      else if (fire) begin
         e_tmp.pc    = fq.imem_req_addr;
         e_tmp.instr = mem_word(fq.imem_req_addr);
         sb.push_back(e_tmp);
      end
   end
   always @(negedge clk) begin
      if (reset && fq.if_valid && fq.id_ready) begin
         pops++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: unexpected instruction at pc %h", fq.if_pc);
         end else begin
            e_chk = sb.pop_front();
            check("sb_pc", fq.if_pc, e_chk.pc);
            check("sb_instr", fq.if_instr, e_chk.instr);
            check("sb_plus4", fq.if_pc_plus4, {e_chk.pc[31], e_chk.pc[30:0] + 31'd4});
         end
      end
   end
   initial begin
      tbl[0] = '{32'h0000_1000, 32'h0000_1004};
      tbl[1] = '{32'h7FFF_FFFC, 32'h0000_0000};
      tbl[2] = '{32'hFFFF_FFFC, 32'h8000_0000};
      tbl[3] = '{32'h8000_0080, 32'h8000_0084};
      tbl[4] = '{32'h8000_0000, 32'h8000_0004};
      fq.redirect = 1'b0;
      fq.id_ready = 1'b1;
      fq.imem_req_ready = 1'b1;
      tgt = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_valid", 32'(fq.imem_req_valid), 32'd0);
      check("rst_pcwrite", 32'(fq.PCWrite), 32'd0);
      check("rst_if_valid", 32'(fq.if_valid), 32'd0);
      check("rst_if_instr", fq.if_instr, 32'd0);
      check("rst_if_pc", fq.if_pc, 32'd0);
      check("rst_plus4", fq.if_pc_plus4, 32'd4);
      @(posedge clk);
      #1 reset = 1'b1;
      #1 check("first_req_valid", 32'(fq.imem_req_valid), 32'd1);
      repeat (30) @(posedge clk);
      #1;
      check("stream_pc_advance", pc_r, 32'(fires * 4));
      check("stream_progress", 32'(pops >= 10), 32'd1);
      settle();
      fq.id_ready = 1'b0;
      fq.imem_req_ready = 1'b1;
      f0 = fires;
      redir(32'h0000_0100);
      repeat (10) @(posedge clk);
      #1;
      check("hold_fires", 32'(fires - f0), 32'd2);
      check("hold_req_valid", 32'(fq.imem_req_valid), 32'd0);
      check("hold_pcwrite", 32'(fq.PCWrite), 32'd0);
      check("hold_pc_frozen", pc_r, 32'h0000_0108);
      check("hold_head_pc", fq.if_pc, 32'h0000_0100);
      p0 = pops;
      fq.id_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("hold_resume", 32'(pops - p0 >= 6), 32'd1);
      settle();
      lat = 3;
      fq.imem_req_ready = 1'b1;
      f0 = fires;
      redir(32'h0000_0200);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("lat3_outstanding", 32'(fires - f0), 32'd2);
      redir(32'h8000_0080);
      wait_valid("lat3_wait", ok);
      if (ok) begin
         check("lat3_pc", fq.if_pc, 32'h8000_0080);
         check("lat3_plus4", fq.if_pc_plus4, 32'h8000_0084);
         check("lat3_instr", fq.if_instr, mem_word(32'h8000_0080));
      end
      settle();
      lat = 1;
      fq.id_ready = 1'b0;
      fq.imem_req_ready = 1'b1;
      redir(32'h0000_0300);
      @(posedge clk);
      #1;
      redir(32'h0000_0400);
      wait_valid("same_cycle_wait", ok);
      if (ok) begin
         check("same_cycle_pc", fq.if_pc, 32'h0000_0400);
         check("same_cycle_instr", fq.if_instr, mem_word(32'h0000_0400));
      end
      settle();
      fq.id_ready = 1'b0;
      fq.imem_req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         redir(tbl[i].pc);
         wait_valid("tbl_wait", ok);
         if (ok) begin
            check("tbl_pc", fq.if_pc, tbl[i].pc);
            check("tbl_plus4", fq.if_pc_plus4, tbl[i].plus4);
            check("tbl_instr", fq.if_instr, mem_word(tbl[i].pc));
         end
      end
      check("pre_rst_valid", 32'(fq.if_valid), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_if_valid", 32'(fq.if_valid), 32'd0);
      check("async_req_valid", 32'(fq.imem_req_valid), 32'd0);
      check("async_pcwrite", 32'(fq.PCWrite), 32'd0);
      check("async_if_pc", fq.if_pc, 32'd0);
      check("async_plus4", fq.if_pc_plus4, 32'd4);
      @(posedge clk);
      #1 reset = 1'b1;
      fq.id_ready = 1'b1;
      p0 = pops;
      repeat (15) @(posedge clk);
      #1;
      check("post_rst_progress", 32'(pops - p0 >= 5), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
